// File: rtl/gpio_access_arbiter_if.sv
// Bundle of request/ack, GPIO strobe and data signals shared by the two requesters and the arbiter.
// Names follow the board-level signal names so traces line up with the schematic.
interface gpio_access_arbiter_if #(
  parameter int GPO_W = 8,
  parameter int GPI_W = 4
) ();
  logic             REQ0;
  logic             WE0;
  logic [GPO_W-1:0] WDATA0;
  logic             ACK0;
  logic             REQ1;
  logic             WE1;
  logic [GPO_W-1:0] WDATA1;
  logic             ACK1;
  logic [GPI_W-1:0] RDATA;
  logic             WR_GPIO;
  logic             RD_GPIO;
  logic [GPO_W-1:0] GPO;
  logic [GPI_W-1:0] GPI;
  logic             BUSY;

  // Requesters plus the board input side; GPI is driven from outside the arbiter.
  modport master (
    output REQ0, WE0, WDATA0, REQ1, WE1, WDATA1, GPI,
    input  ACK0, ACK1, RDATA, WR_GPIO, RD_GPIO, GPO, BUSY
  );

  modport slave (
    input  REQ0, WE0, WDATA0, REQ1, WE1, WDATA1, GPI,
    output ACK0, ACK1, RDATA, WR_GPIO, RD_GPIO, GPO, BUSY
  );
endinterface

// File: rtl/gpio_access_arbiter.sv
// Round-robin arbiter sharing one GPIO port between the CPU path (port 0) and the debug path (port 1).
// One access in flight: IDLE -> ACCESS (strobe) -> DONE (ack); every output is a flop.
module gpio_access_arbiter #(
  parameter int GPO_W = 8,
  parameter int GPI_W = 4
) (
  input logic            CLK,
  input logic            RESETN,
  gpio_access_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_q;
  logic             win_q;
  logic             we_q;
  logic [GPO_W-1:0] gpo_q;
  logic [GPI_W-1:0] rdata_q;
  logic             ack0_q, ack1_q;
  logic             wr_q, rd_q;
  logic             busy_q;

  logic             any_req;
  logic             win_d;
  logic             sel_we;
  logic [GPO_W-1:0] sel_wdata;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    any_req   = bus.REQ0 | bus.REQ1;
    // On a tie the port that did not win last time gets the grant.
    win_d     = (bus.REQ0 & bus.REQ1) ? ~last_q : bus.REQ1;
    sel_we    = win_d ? bus.WE1 : bus.WE0;
    sel_wdata = win_d ? bus.WDATA1 : bus.WDATA0;
    state_d   = state_q;
    case (state_q)
      S_IDLE:   if (any_req) state_d = S_ACCESS;
      S_ACCESS: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments in the clocked block so every flop samples pre-edge values,
  // independent of statement order.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      gpo_q   <= '0;
      rdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Strobes, acks and busy are pulses; only the state arms below raise them.
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            win_q  <= win_d;
            last_q <= win_d;
            we_q   <= sel_we;
            wr_q   <= sel_we;
            rd_q   <= ~sel_we;
            busy_q <= 1'b1;
            if (sel_we) gpo_q <= sel_wdata;
          end
        end
        S_ACCESS: begin
          ack0_q <= ~win_q;
          ack1_q <= win_q;
          busy_q <= 1'b1;
          if (!we_q) rdata_q <= bus.GPI;
        end
        default: ;
      endcase
    end
  end

  assign bus.ACK0    = ack0_q;
  assign bus.ACK1    = ack1_q;
  assign bus.RDATA   = rdata_q;
  assign bus.WR_GPIO = wr_q;
  assign bus.RD_GPIO = rd_q;
  assign bus.GPO     = gpo_q;
  assign bus.BUSY    = busy_q;

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Bench for gpio_access_arbiter: directed vector table, hand-written reset corner cases,
// then randomized requesters checked against a transaction-timeline reference model.
module tb_gpio_access_arbiter;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  gpio_access_arbiter_if #(.GPO_W(8), .GPI_W(4)) bus ();

  gpio_access_arbiter #(.GPO_W(8), .GPI_W(4)) dut (
    .CLK   (clk),
    .RESETN(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output snapshot layout: {ACK0, ACK1, WR_GPIO, RD_GPIO, BUSY, GPO[7:0], RDATA[3:0]}
  function automatic logic [16:0] get_out();
    return {bus.ACK0, bus.ACK1, bus.WR_GPIO, bus.RD_GPIO, bus.BUSY, bus.GPO, bus.RDATA};
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (ack0 ack1 wr rd busy gpo rdata)", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        rst_n;
    logic        req0, we0;
    logic [7:0]  wd0;
    logic        req1, we1;
    logic [7:0]  wd1;
    logic [3:0]  gpi;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic rn,
                     input logic r0, input logic w0, input logic [7:0] d0,
                     input logic r1, input logic w1, input logic [7:0] d1,
                     input logic [3:0] gpi,
                     input logic a0, input logic a1, input logic wr, input logic rd,
                     input logic bsy, input logic [7:0] gpo, input logic [3:0] rdat);
    vec_t v;
    v.name = name; v.rst_n = rn;
    v.req0 = r0; v.we0 = w0; v.wd0 = d0;
    v.req1 = r1; v.we1 = w1; v.wd1 = d1;
    v.gpi  = gpi;
    v.exp  = {a0, a1, wr, rd, bsy, gpo, rdat};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [7:0] d1,
                       input logic [3:0] gpi);
    bus.REQ0 = r0; bus.WE0 = w0; bus.WDATA0 = d0;
    bus.REQ1 = r1; bus.WE1 = w1; bus.WDATA1 = d1;
    bus.GPI  = gpi;
  endtask

  // Reference model: each grant is a transaction placed on a timeline of clock edges.
  // Grant at edge e -> strobe visible after edge e, ack after edge e+1, next grant no earlier than e+3.
  int         m_cyc;
  int         m_grant_e;
  int         m_next_free;
  logic       m_last;
  logic       m_w;
  logic       m_we;
  logic [7:0] m_gpo;
  logic [3:0] m_rdata;

  task automatic model_reset();
    m_cyc = 0; m_grant_e = -100; m_next_free = 0;
    m_last = 1'b1; m_w = 1'b0; m_we = 1'b0;
    m_gpo = 8'h00; m_rdata = 4'h0;
  endtask

  task automatic model_edge(input logic r0, input logic w0, input logic [7:0] d0,
                            input logic r1, input logic w1, input logic [7:0] d1,
                            input logic [3:0] gpi);
    logic w;
    m_cyc++;
    if (m_cyc == m_grant_e + 1 && !m_we) m_rdata = gpi;
    if (m_cyc >= m_next_free && (r0 || r1)) begin
      if (r0 && r1) w = (m_last == 1'b0) ? 1'b1 : 1'b0;
      else          w = r1;
      m_w = w;
      m_we = w ? w1 : w0;
      m_grant_e = m_cyc;
      m_next_free = m_cyc + 3;
      m_last = w;
      if (m_we) m_gpo = w ? d1 : d0;
    end
  endtask

  function automatic logic [16:0] model_out();
    logic s, a;
    s = (m_cyc == m_grant_e);
    a = (m_cyc == m_grant_e + 1);
    return {a && !m_w, a && m_w, s && m_we, s && !m_we, s || a, m_gpo, m_rdata};
  endfunction

  logic       rq [2];
  logic       rwe[2];
  logic [7:0] rwd[2];
  logic       hold_off[2];
  logic [3:0] rgpi;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0);

    //   name         rst r0 w0 d0     r1 w1 d1     gpi   a0 a1 wr rd bsy gpo    rdata
    add("rst_hold0",  0, 1, 1, 8'h01, 0, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 8'h00, 4'h0);
    add("rst_hold1",  0, 1, 1, 8'h01, 0, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 8'h00, 4'h0);
    add("wr_strobe",  1, 1, 1, 8'h01, 0, 0, 8'h00, 4'h0, 0, 0, 1, 0, 1, 8'h01, 4'h0);
    add("wr_ack",     1, 1, 1, 8'h01, 0, 0, 8'h00, 4'h0, 1, 0, 0, 0, 1, 8'h01, 4'h0);
    add("wr_idle0",   1, 0, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 8'h01, 4'h0);
    add("wr_idle1",   1, 0, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 8'h01, 4'h0);
    add("rd_strobe",  1, 0, 0, 8'h00, 1, 0, 8'h00, 4'h4, 0, 0, 0, 1, 1, 8'h01, 4'h0);
    add("rd_ack",     1, 0, 0, 8'h00, 1, 0, 8'h00, 4'h4, 0, 1, 0, 0, 1, 8'h01, 4'h4);
    add("rd_idle",    1, 0, 0, 8'h00, 0, 0, 8'h00, 4'h4, 0, 0, 0, 0, 0, 8'h01, 4'h4);
    add("rst_again",  0, 0, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 8'h00, 4'h0);
    add("rr_g0",      1, 1, 1, 8'h10, 1, 1, 8'h20, 4'h0, 0, 0, 1, 0, 1, 8'h10, 4'h0);
    add("rr_a0",      1, 1, 1, 8'h10, 1, 1, 8'h20, 4'h0, 1, 0, 0, 0, 1, 8'h10, 4'h0);
    add("rr_i0",      1, 1, 1, 8'h10, 1, 1, 8'h20, 4'h0, 0, 0, 0, 0, 0, 8'h10, 4'h0);
    add("rr_g1",      1, 1, 1, 8'h10, 1, 1, 8'h20, 4'h0, 0, 0, 1, 0, 1, 8'h20, 4'h0);
    add("rr_a1",      1, 1, 1, 8'h10, 1, 1, 8'h20, 4'h0, 0, 1, 0, 0, 1, 8'h20, 4'h0);
    add("rr_i1",      1, 1, 1, 8'h10, 1, 1, 8'h20, 4'h0, 0, 0, 0, 0, 0, 8'h20, 4'h0);
    add("rr_g0b",     1, 1, 1, 8'h10, 1, 1, 8'h20, 4'h0, 0, 0, 1, 0, 1, 8'h10, 4'h0);
    add("rr_a0b",     1, 1, 1, 8'h10, 1, 1, 8'h20, 4'h0, 1, 0, 0, 0, 1, 8'h10, 4'h0);
    add("rr_drop",    1, 0, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 8'h10, 4'h0);
    add("drop_g",     1, 1, 1, 8'h80, 0, 0, 8'h00, 4'h0, 0, 0, 1, 0, 1, 8'h80, 4'h0);
    add("drop_a",     1, 0, 0, 8'h00, 0, 0, 8'h00, 4'h0, 1, 0, 0, 0, 1, 8'h80, 4'h0);
    add("drop_i",     1, 0, 0, 8'h00, 0, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 8'h80, 4'h0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n;
      drive(vecs[i].req0, vecs[i].we0, vecs[i].wd0, vecs[i].req1, vecs[i].we1, vecs[i].wd1, vecs[i].gpi);
      @(posedge clk);
      @(negedge clk);
      check(vecs[i].name, get_out(), vecs[i].exp);
    end

    // Reset asserted mid-ACCESS: outputs clear without waiting for a clock, no ack follows,
    // and the tie-break returns to port 0.
    drive(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 4'h0);
    @(posedge clk);
    @(negedge clk);
    check("t6_strobe", get_out(), {5'b00101, 8'h33, 4'h0});
    rst_n = 1'b0;
    #1;
    check("t6_async", get_out(), 17'h0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0);
    @(posedge clk);
    @(negedge clk);
    check("t6_noack", get_out(), 17'h0);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 4'h0);
    @(posedge clk);
    @(negedge clk);
    check("t6_p0wins", get_out(), {5'b00101, 8'h11, 4'h0});
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0);
    @(posedge clk);
    @(negedge clk);
    check("t6_ack0", get_out(), {5'b10001, 8'h11, 4'h0});

    // Randomized requesters against the timeline model.
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; rwe[p] = 1'b0; rwd[p] = 8'h00; hold_off[p] = 1'b0;
    end
    for (int n = 0; n < 800; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (hold_off[p]) begin
          hold_off[p] = 1'b0;
        end else if (!rq[p]) begin
          if ($urandom_range(2) == 0) begin
            rq[p]  = 1'b1;
            rwe[p] = 1'($urandom_range(1));
            rwd[p] = 8'($urandom);
          end
        end else if ($urandom_range(19) == 0) begin
          rq[p] = 1'b0;
        end
      end
      rgpi = 4'($urandom);
      drive(rq[0], rwe[0], rwd[0], rq[1], rwe[1], rwd[1], rgpi);
      @(posedge clk);
      model_edge(rq[0], rwe[0], rwd[0], rq[1], rwe[1], rwd[1], rgpi);
      @(negedge clk);
      check("rand", get_out(), model_out());
      if (bus.ACK0) begin rq[0] = 1'b0; hold_off[0] = 1'b1; end
      if (bus.ACK1) begin rq[1] = 1'b0; hold_off[1] = 1'b1; end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
